order_book_arbiter: RTL and testbench
=====================================

// Module: order_book_arbiter
// PURPOSE
//  Shares one order_book instance between NUM_REQ order sources (feed handlers, strategy, risk).
//  Round-robin arbitration picks one pending request and drives the book's valid/field bus.
//  The request is held until the book answers with ready, then the top-of-book is captured.
//  The captured snapshot is returned to the winning requester with a one-cycle done pulse.
//  Sits between the requester fabric and the order_book in the per-stock pipeline.
// PARAMETERS
//  NUM_REQ         4     number of requesters, 2..8
//  TIMEOUT_CYCLES  1024  WAIT cycles without ob_ready before the transaction is aborted
// PORTS
//  clk             in   1           system clock, rising edge
//  reset           in   1           synchronous, active-high
//  req_valid       in   NUM_REQ     per-requester request pending; held until req_ack
//  req_order_id    in   NUM_REQ*32  order id, requester k at [32k+:32]
//  req_quantity    in   NUM_REQ*32  quantity, [32k+:32]
//  req_price       in   NUM_REQ*64  price, [64k+:64]
//  req_type        in   NUM_REQ*3   request type (3'b100 add, 3'b001 cancel/modify), [3k+:3]
//  req_ack         out  NUM_REQ     one-hot pulse: request captured, requester may drop valid
//  done            out  NUM_REQ     one-hot pulse: transaction for requester k complete
//  error           out  1           pulse with done: transaction aborted by timeout
//  bbo_order_id    out  32          captured max_order_id, valid on done
//  bbo_quantity    out  32          captured max_quantity
//  bbo_price       out  64          captured max_price
//  ob_valid        out  1           to order_book valid
//  ob_order_id     out  32          to order_book order_id
//  ob_quantity     out  32          to order_book quantity
//  ob_price        out  64          to order_book price
//  ob_req_type     out  3           to order_book req_type
//  ob_ready        in   1           from order_book ready
//  ob_max_order_id in   32          from order_book max_order_id
//  ob_max_quantity in   32          from order_book max_quantity
//  ob_max_price    in   64          from order_book max_price
//  busy            out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, round-robin pointer = 0, timeout counter = 0.
//  All outputs are registered. Reset asserted mid-transaction aborts it at once.
//   ob_valid drops the next cycle. No done or error is raised.
//  FSM:
//   IDLE:  if ob_ready==0 and any req_valid, take the winner = first set bit at or after the pointer, wrapping.
//          Latch its fields into ob_*, pulse req_ack[winner], go to ISSUE.
//          While ob_ready==1, do not grant (the book is still finishing).
//   ISSUE: ob_valid=1, clear the timeout counter, go to WAIT. The grant-to-ob_valid latency is 1 cycle.
//   WAIT:  ob_valid stays 1 and ob_* stay stable.
//          ob_ready==1: capture ob_max_* into bbo_*, ob_valid=0, pulse done[winner], go to GAP.
//          Counter reaches TIMEOUT_CYCLES-1: ob_valid=0, bbo_* unchanged, pulse done[winner] and error, go to GAP.
//   GAP:   ob_valid=0 for exactly 1 cycle, pointer = winner+1 (mod NUM_REQ), go to IDLE.
//  Throughput: at most one transaction per 4 cycles plus the order_book latency.
//  req_valid that falls before req_ack withdraws the request, with no side effects.
//  The winner's req_valid is not sampled after req_ack. A requester that re-raises valid competes normally.
//  Simultaneous requests: exactly one req_ack per grant. A requester with valid held is granted
//   within NUM_REQ grants (no starvation).
//  done and req_ack are never asserted for two requesters in the same cycle.
//  Timeout counter is 16 bits and saturates. TIMEOUT_CYCLES=0 disables the timeout.
//  bbo_* hold their value until the next successful capture.
// CONFIGURATION
//  ORDER_BOOK_ARB_PRIO_EN defined: requester 0 (risk/cancel path) has strict priority.
//   It wins whenever req_valid[0]=1 in IDLE. The pointer is not updated when 0 wins.
//   Requesters 1..NUM_REQ-1 are round-robin among themselves.
//  Not defined: pure round-robin over all NUM_REQ requesters, exactly as in BEHAVIOUR.
// TESTING
//  1 Single add: req 2 sends id=7, qty=32'h435365, price=140, type=100. Model book ready 3 cycles after valid.
//    -> req_ack[2] in the grant cycle, ob_valid 1 cycle later.
//    -> done[2] with bbo_* = model max, then ob_valid low for 1 cycle.
//  2 All 4 valid continuously, pointer 0.
//    -> grants in order 0,1,2,3,0. With PRIO_EN: 0,0,0... while req 0 held, 1,2,3 only after req 0 drops.
//  3 200 back-to-back adds from req 1, id=i, price=i*20, then cancel id=40, qty=32'hF.
//    -> 201 done[1] pulses, none lost, none duplicated.
//  4 Book never asserts ready, TIMEOUT_CYCLES=16.
//    -> done+error 16 cycles after ob_valid rises, bbo_* unchanged, next request granted afterwards.
//  5 reset asserted in WAIT.
//    -> next cycle: ob_valid=0, state IDLE, no done. A pending request is granted after reset.
//  6 ob_ready held high in IDLE with req 3 valid.
//    -> no req_ack until ob_ready falls; grant the cycle after.

Source files
------------

// File: rtl/order_book_arbiter.sv
// rtl/order_book_arbiter.sv - round-robin arbiter sharing one order_book between NUM_REQ requesters
// Optional: define ORDER_BOOK_ARB_PRIO_EN to give requester 0 strict priority.
module order_book_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_order_id,
  input  logic [NUM_REQ*32-1:0]   req_quantity,
  input  logic [NUM_REQ*64-1:0]   req_price,
  input  logic [NUM_REQ*3-1:0]    req_type,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      done,
  output logic                    error,
  output logic [31:0]             bbo_order_id,
  output logic [31:0]             bbo_quantity,
  output logic [63:0]             bbo_price,
  output logic                    ob_valid,
  output logic [31:0]             ob_order_id,
  output logic [31:0]             ob_quantity,
  output logic [63:0]             ob_price,
  output logic [2:0]              ob_req_type,
  input  logic                    ob_ready,
  input  logic [31:0]             ob_max_order_id,
  input  logic [31:0]             ob_max_quantity,
  input  logic [63:0]             ob_max_price,
  output logic                    busy
);

  localparam int          PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d, win_q, win_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d, done_q, done_d;
  logic                 err_q, err_d, obv_q, obv_d, busy_q, busy_d;
  logic [31:0]          ob_id_q, ob_id_d, ob_qty_q, ob_qty_d;
  logic [63:0]          ob_px_q, ob_px_d;
  logic [2:0]           ob_typ_q, ob_typ_d;
  logic [31:0]          bbo_id_q, bbo_id_d, bbo_qty_q, bbo_qty_d;
  logic [63:0]          bbo_px_q, bbo_px_d;

  logic [NUM_REQ-1:0]   elig;
  logic                 found;
  logic [PW-1:0]        pick, idx, ptr_next;
  logic [PW:0]          sum;

  // Rotating search: first eligible requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    sum   = '0;
`ifdef ORDER_BOOK_ARB_PRIO_EN
    elig  = req_valid & ~NUM_REQ'(1);
`else
    elig  = req_valid;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
`ifdef ORDER_BOOK_ARB_PRIO_EN
    if (req_valid[0]) begin
      found = 1'b1;
      pick  = '0;
    end
`endif
  end

  assign ptr_next = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    obv_d     = obv_q;
    ob_id_d   = ob_id_q;
    ob_qty_d  = ob_qty_q;
    ob_px_d   = ob_px_q;
    ob_typ_d  = ob_typ_q;
    bbo_id_d  = bbo_id_q;
    bbo_qty_d = bbo_qty_q;
    bbo_px_d  = bbo_px_q;
    case (state_q)
      S_IDLE: begin
        // A high ob_ready here means the book is still finishing the previous request.
        if (!ob_ready && found) begin
          win_d       = pick;
          ob_id_d     = req_order_id[pick*32 +: 32];
          ob_qty_d    = req_quantity[pick*32 +: 32];
          ob_px_d     = req_price[pick*64 +: 64];
          ob_typ_d    = req_type[pick*3 +: 3];
          ack_d[pick] = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        obv_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ob_ready) begin
          bbo_id_d      = ob_max_order_id;
          bbo_qty_d     = ob_max_quantity;
          bbo_px_d      = ob_max_price;
          obv_d         = 1'b0;
          done_d[win_q] = 1'b1;
          state_d       = S_GAP;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          obv_d         = 1'b0;
          done_d[win_q] = 1'b1;
          err_d         = 1'b1;
          state_d       = S_GAP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
`ifdef ORDER_BOOK_ARB_PRIO_EN
        if (win_q != '0) ptr_d = ptr_next;
`else
        ptr_d = ptr_next;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      obv_q     <= 1'b0;
      busy_q    <= 1'b0;
      ob_id_q   <= '0;
      ob_qty_q  <= '0;
      ob_px_q   <= '0;
      ob_typ_q  <= '0;
      bbo_id_q  <= '0;
      bbo_qty_q <= '0;
      bbo_px_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      obv_q     <= obv_d;
      busy_q    <= busy_d;
      ob_id_q   <= ob_id_d;
      ob_qty_q  <= ob_qty_d;
      ob_px_q   <= ob_px_d;
      ob_typ_q  <= ob_typ_d;
      bbo_id_q  <= bbo_id_d;
      bbo_qty_q <= bbo_qty_d;
      bbo_px_q  <= bbo_px_d;
    end
  end

  assign req_ack      = ack_q;
  assign done         = done_q;
  assign error        = err_q;
  assign bbo_order_id = bbo_id_q;
  assign bbo_quantity = bbo_qty_q;
  assign bbo_price    = bbo_px_q;
  assign ob_valid     = obv_q;
  assign ob_order_id  = ob_id_q;
  assign ob_quantity  = ob_qty_q;
  assign ob_price     = ob_px_q;
  assign ob_req_type  = ob_typ_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_order_book_arbiter.sv
// tb/tb_order_book_arbiter.sv - directed vector bench for order_book_arbiter with a small order_book model
module tb_order_book_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_order_id, req_quantity;
  logic [N*64-1:0] req_price;
  logic [N*3-1:0]  req_type;
  logic [N-1:0]    req_ack, done;
  logic            error, ob_valid, ob_ready, busy;
  logic [31:0]     bbo_order_id, bbo_quantity, ob_order_id, ob_quantity;
  logic [63:0]     bbo_price, ob_price;
  logic [2:0]      ob_req_type;
  logic [31:0]     ob_max_order_id, ob_max_quantity;
  logic [63:0]     ob_max_price;

  always #5 clk = ~clk;

  order_book_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_order_id(req_order_id),
    .req_quantity(req_quantity), .req_price(req_price), .req_type(req_type),
    .req_ack(req_ack), .done(done), .error(error), .bbo_order_id(bbo_order_id),
    .bbo_quantity(bbo_quantity), .bbo_price(bbo_price), .ob_valid(ob_valid),
    .ob_order_id(ob_order_id), .ob_quantity(ob_quantity), .ob_price(ob_price),
    .ob_req_type(ob_req_type), .ob_ready(ob_ready), .ob_max_order_id(ob_max_order_id),
    .ob_max_quantity(ob_max_quantity), .ob_max_price(ob_max_price), .busy(busy)
  );

  typedef struct {
    int          k;
    logic [31:0] id, qty;
    logic [63:0] px;
    logic [2:0]  typ;
    int          lat;
    logic [31:0] bk_id, bk_qty;
    logic [63:0] bk_px;
    logic [N-1:0] exp_onehot;
    int          exp_dly;
  } vec_t;

  vec_t        vec [4];
  int          total = 0, bad = 0, cyc = 0, viol = 0;
  int          done_cnt [N];
  bit          model_en;
  int          book_lat, vcnt;
  logic [31:0] bk_id, bk_qty, exp_bid, exp_bqty;
  logic [63:0] bk_px, exp_bpx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample #1 after the edge, track pulses, then let the book model react.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!$onehot0(req_ack) || !$onehot0(done) || (error && done == '0)) viol++;
    for (int k = 0; k < N; k++) if (done[k]) done_cnt[k]++;
    if (model_en) begin
      if (ob_valid) begin
        vcnt++;
        ob_ready = (book_lat != 0) && (vcnt > book_lat);
      end else begin
        vcnt     = 0;
        ob_ready = 1'b0;
      end
      if (ob_ready) begin
        ob_max_order_id = bk_id;
        ob_max_quantity = bk_qty;
        ob_max_price    = bk_px;
      end else begin
        ob_max_order_id = 32'hBAD0BAD0;
        ob_max_quantity = 32'hBAD1BAD1;
        ob_max_price    = 64'hBAD2BAD2BAD2BAD2;
      end
    end
  endtask

  task automatic set_req(input int k, input logic [31:0] id, input logic [31:0] qty,
                         input logic [63:0] px, input logic [2:0] typ);
    req_order_id[k*32 +: 32] = id;
    req_quantity[k*32 +: 32] = qty;
    req_price[k*64 +: 64]    = px;
    req_type[k*3 +: 3]       = typ;
  endtask

  task automatic wait_ack(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      seen = (req_ack != '0);
    end
    chk(name, seen, 1);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      seen = (done != '0);
    end
    chk(name, seen, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    exp_bid = '0; exp_bqty = '0; exp_bpx = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, acks, d3, idbad;
    int order [5];
    reset = 1'b1; req_valid = '0; req_order_id = '0; req_quantity = '0;
    req_price = '0; req_type = '0; ob_ready = 1'b0; ob_max_order_id = '0;
    ob_max_quantity = '0; ob_max_price = '0; model_en = 1'b1; book_lat = 1; vcnt = 0;
    bk_id = '0; bk_qty = '0; bk_px = '0;
    for (int k = 0; k < N; k++) done_cnt[k] = 0;

    repeat (3) tick();
    chk("rst_req_ack", req_ack, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ob_valid", ob_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bbo_order_id", bbo_order_id, 0);
    chk("rst_bbo_price", bbo_price, 0);
    chk("rst_ob_order_id", ob_order_id, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Single transactions; row 0 is the reference add from requester 2.
    vec[0] = '{2, 32'd7, 32'h435365, 64'd140, 3'b100, 3, 32'd7, 32'h435365, 64'd140, 4'b0100, 4};
    vec[1] = '{0, 32'h11, 32'd5, 64'h1_0000_0000, 3'b100, 1, 32'h3, 32'h99, 64'hDEADBEEF00000001, 4'b0001, 2};
    vec[2] = '{3, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'b001, 5, 32'd1, 32'd2, 64'd3, 4'b1000, 6};
    vec[3] = '{1, 32'd0, 32'd0, 64'd0, 3'b001, 2, 32'hA5A5A5A5, 32'h5A5A5A5A, 64'h0123456789ABCDEF, 4'b0010, 3};
    for (int v = 0; v < 4; v++) begin
      book_lat = vec[v].lat; bk_id = vec[v].bk_id; bk_qty = vec[v].bk_qty; bk_px = vec[v].bk_px;
      set_req(vec[v].k, vec[v].id, vec[v].qty, vec[v].px, vec[v].typ);
      req_valid[vec[v].k] = 1'b1;
      wait_ack($sformatf("v%0d_ack_seen", v));
      chk($sformatf("v%0d_req_ack", v), req_ack, vec[v].exp_onehot);
      chk($sformatf("v%0d_ob_valid_at_ack", v), ob_valid, 0);
      chk($sformatf("v%0d_ob_order_id", v), ob_order_id, vec[v].id);
      chk($sformatf("v%0d_ob_quantity", v), ob_quantity, vec[v].qty);
      chk($sformatf("v%0d_ob_price", v), ob_price, vec[v].px);
      chk($sformatf("v%0d_ob_req_type", v), ob_req_type, vec[v].typ);
      req_valid = '0;
      tick();
      chk($sformatf("v%0d_ob_valid_rise", v), ob_valid, 1);
      c0 = cyc;
      wait_done($sformatf("v%0d_done_seen", v));
      chk($sformatf("v%0d_done", v), done, vec[v].exp_onehot);
      chk($sformatf("v%0d_error", v), error, 0);
      chk($sformatf("v%0d_done_delay", v), cyc - c0, vec[v].exp_dly);
      chk($sformatf("v%0d_bbo_order_id", v), bbo_order_id, vec[v].bk_id);
      chk($sformatf("v%0d_bbo_quantity", v), bbo_quantity, vec[v].bk_qty);
      chk($sformatf("v%0d_bbo_price", v), bbo_price, vec[v].bk_px);
      chk($sformatf("v%0d_ob_valid_drop", v), ob_valid, 0);
      chk($sformatf("v%0d_busy_gap", v), busy, 1);
      tick();
      chk($sformatf("v%0d_done_pulse", v), done, 0);
      chk($sformatf("v%0d_busy_idle", v), busy, 0);
    end

    // All four requesters hold valid from pointer 0.
    do_reset();
`ifdef ORDER_BOOK_ARB_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    book_lat = 1; bk_id = 32'h77; bk_qty = 32'h88; bk_px = 64'h99;
    for (int k = 0; k < N; k++) set_req(k, 32'd100 + 32'(k), 32'd1, 64'd1, 3'b100);
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      wait_ack($sformatf("rr%0d_ack_seen", g));
      chk($sformatf("rr%0d_grant", g), req_ack, 4'b0001 << order[g]);
      chk($sformatf("rr%0d_ob_order_id", g), ob_order_id, 32'd100 + 32'(order[g]));
    end
    req_valid = '0;
    wait_done("rr_last_done_seen");
    repeat (3) tick();
    exp_bid = bk_id; exp_bqty = bk_qty; exp_bpx = bk_px;

    // 200 back-to-back adds from requester 1, then a cancel.
    done_cnt[1] = 0;
    idbad = 0;
    book_lat = 1; bk_id = 32'h1234; bk_qty = 32'h5678; bk_px = 64'h9ABC;
    for (int i = 0; i <= 200; i++) begin
      if (i < 200) set_req(1, 32'(i), 32'(i + 1), 64'(i * 20), 3'b100);
      else         set_req(1, 32'd40, 32'hF, 64'd800, 3'b001);
      req_valid[1] = 1'b1;
      wait_ack($sformatf("b2b%0d_ack_seen", i));
      if (i < 200 && (ob_order_id !== 32'(i) || ob_price !== 64'(i * 20) || req_ack !== 4'b0010)) idbad++;
      if (i == 200) begin
        chk("b2b_cancel_id", ob_order_id, 40);
        chk("b2b_cancel_qty", ob_quantity, 32'hF);
        chk("b2b_cancel_type", ob_req_type, 3'b001);
      end
    end
    req_valid = '0;
    for (int i = 0; i < 60 && done_cnt[1] < 201; i++) tick();
    repeat (10) tick();
    chk("b2b_done_count", done_cnt[1], 201);
    chk("b2b_field_errors", idbad, 0);
    exp_bid = bk_id; exp_bqty = bk_qty; exp_bpx = bk_px;

    // Book never answers: abort after 16 WAIT cycles, bbo untouched.
    book_lat = 0;
    set_req(0, 32'hAB, 32'd9, 64'd9, 3'b100);
    req_valid[0] = 1'b1;
    wait_ack("to_ack_seen");
    chk("to_req_ack", req_ack, 4'b0001);
    req_valid = '0;
    tick();
    chk("to_ob_valid_rise", ob_valid, 1);
    c0 = cyc;
    wait_done("to_done_seen");
    chk("to_done", done, 4'b0001);
    chk("to_error", error, 1);
    chk("to_delay", cyc - c0, 16);
    chk("to_bbo_order_id", bbo_order_id, exp_bid);
    chk("to_bbo_quantity", bbo_quantity, exp_bqty);
    chk("to_bbo_price", bbo_price, exp_bpx);
    chk("to_ob_valid_drop", ob_valid, 0);
    tick();
    chk("to_error_pulse", error, 0);
    book_lat = 2; bk_id = 32'hC0FFEE; bk_qty = 32'h42; bk_px = 64'h4242;
    set_req(2, 32'h22, 32'd2, 64'd2, 3'b100);
    req_valid[2] = 1'b1;
    wait_ack("to_next_ack_seen");
    chk("to_next_req_ack", req_ack, 4'b0100);
    req_valid = '0;
    wait_done("to_next_done_seen");
    chk("to_next_error", error, 0);
    chk("to_next_bbo_order_id", bbo_order_id, 32'hC0FFEE);

    // Reset while WAITing, with requester 1 pending.
    book_lat = 0;
    set_req(3, 32'h33, 32'd3, 64'd3, 3'b100);
    req_valid[3] = 1'b1;
    wait_ack("rw_ack_seen");
    req_valid = '0;
    repeat (3) tick();
    chk("rw_in_wait_ob_valid", ob_valid, 1);
    d3 = done_cnt[3];
    set_req(1, 32'h55, 32'd5, 64'd5, 3'b100);
    req_valid[1] = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_ob_valid", ob_valid, 0);
    chk("rw_busy", busy, 0);
    chk("rw_done", done, 0);
    chk("rw_error", error, 0);
    chk("rw_bbo_cleared", bbo_order_id, 0);
    book_lat = 2; bk_id = 32'h600D; bk_qty = 32'h6; bk_px = 64'h66;
    wait_ack("rw_pending_ack_seen");
    chk("rw_pending_grant", req_ack, 4'b0010);
    req_valid = '0;
    wait_done("rw_pending_done_seen");
    chk("rw_pending_done", done, 4'b0010);
    chk("rw_pending_bbo", bbo_order_id, 32'h600D);
    chk("rw_no_done_for_aborted", done_cnt[3], d3);
    tick();

    // ob_ready high in IDLE blocks the grant until it falls.
    model_en = 1'b0;
    ob_ready = 1'b1;
    set_req(3, 32'h44, 32'd4, 64'd4, 3'b100);
    req_valid[3] = 1'b1;
    acks = 0;
    repeat (6) begin
      tick();
      if (req_ack != '0) acks++;
    end
    chk("rdy_no_grant_while_ready", acks, 0);
    chk("rdy_busy_low", busy, 0);
    ob_ready = 1'b0;
    tick();
    chk("rdy_grant_after_fall", req_ack, 4'b1000);
    model_en = 1'b1; book_lat = 1; bk_id = 32'h44; bk_qty = 32'h4; bk_px = 64'h4;
    req_valid = '0;
    wait_done("rdy_done_seen");
    chk("rdy_done", done, 4'b1000);
    repeat (2) tick();

    chk("onehot_pulse_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
